// File: rtl/pingpong_bank.sv
// Ping-pong SRAM pair: one bank takes writes while the other serves reads; roles swap on restart.
// Latency: read data, valid and stale flag register 1 cycle after rd_en; no backpressure, every strobe is accepted.
// Optional PINGPONG_AUTOSWAP_EN: also swap on the edge after bank_full rises, without a restart.
module pingpong_bank #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 16,
  localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_stale,
  output logic              wr_bank,
  output logic              bank_full,
  output logic              swap_err
);

  logic [DATA_W-1:0] mem0 [WIDTH];
  logic [DATA_W-1:0] mem1 [WIDTH];
  logic [WIDTH-1:0]  bitmap0, bitmap1;

  logic [WIDTH-1:0]  wr_mask, wr_bm, rd_bm, wr_bm_next;
  logic [DATA_W-1:0] rd_word;
  logic              do_swap;

  always_comb begin
    wr_mask    = wr_en ? (WIDTH'(1) << wr_addr) : '0;
    wr_bm      = wr_bank ? bitmap1 : bitmap0;
    rd_bm      = wr_bank ? bitmap0 : bitmap1;
    wr_bm_next = wr_bm | wr_mask;
    rd_word    = wr_bank ? mem0[rd_addr] : mem1[rd_addr];
`ifdef PINGPONG_AUTOSWAP_EN
    // bank_full is only ever high for one edge here, so a coincident restart still toggles once
    do_swap    = restart | bank_full;
`else
    do_swap    = restart;
`endif
  end

  // SRAM contents survive reset; only the bitmaps say what is valid
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      if (wr_bank) mem1[wr_addr] <= wr_data;
      else         mem0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      bitmap0   <= '0;
      bitmap1   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_stale  <= 1'b0;
      bank_full <= 1'b0;
      swap_err  <= 1'b0;
    end else begin
      // A same-edge write counts in the outgoing write bank, which becomes the read bank
      if (wr_bank) bitmap1 <= wr_bm_next;
      else         bitmap0 <= wr_bm_next;
      if (do_swap) begin
        if (wr_bank) bitmap0 <= '0;
        else         bitmap1 <= '0;
        wr_bank <= ~wr_bank;
      end
      bank_full <= do_swap ? 1'b0 : &wr_bm_next;
      swap_err  <= restart & ~bank_full;
      rd_valid  <= rd_en;
      if (rd_en) begin
        rd_stale <= ~rd_bm[rd_addr];
        rd_data  <= rd_bm[rd_addr] ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_bank.sv
// Directed bench for pingpong_bank: each task drives one scenario and checks outputs 1ns after the edge.
module tb_pingpong_bank;
  logic        clk = 1'b0;
  logic        rst, restart, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, rd_stale, wr_bank, bank_full, swap_err;
  int checks = 0;
  int errors = 0;

  pingpong_bank #(.WIDTH(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_stale(rd_stale), .wr_bank(wr_bank),
    .bank_full(bank_full), .swap_err(swap_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    restart = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); wr_addr = 0; wr_data = 0; rd_addr = 0;
    tick(); tick();
    checks++; if (wr_bank !== 1'b0)  begin errors++; $display("FAIL reset_wr_bank got %b exp 0", wr_bank); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    checks++; if ({rd_valid, rd_stale, bank_full, swap_err} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got %b exp 0000", {rd_valid, rd_stale, bank_full, swap_err}); end
    rst = 1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 16'h0100 + 16'(a);
      tick();
      checks++; if (bank_full !== (a == 15))
        begin errors++; $display("FAIL fill_bank_full addr %0d got %b exp %b", a, bank_full, a == 15); end
    end
    idle(); tick();
    checks++; if (wr_bank !== 1'b0 || swap_err !== 1'b0 || bank_full !== 1'b1)
      begin errors++; $display("FAIL fill_state got bank %b err %b full %b exp 0 0 1", wr_bank, swap_err, bank_full); end
  endtask

  task automatic test_swap_read();
    restart = 1; tick(); idle();
    checks++; if (wr_bank !== 1'b1 || swap_err !== 1'b0 || bank_full !== 1'b0)
      begin errors++; $display("FAIL swap_state got bank %b err %b full %b exp 1 0 0", wr_bank, swap_err, bank_full); end
    for (int a = 0; a < 16; a++) begin
      rd_en = 1; rd_addr = 4'(a);
      tick();
      checks++; if (rd_data !== 16'h0100 + 16'(a) || rd_valid !== 1'b1 || rd_stale !== 1'b0)
        begin errors++; $display("FAIL swap_read addr %0d got %h v%b s%b exp %h v1 s0", a, rd_data, rd_valid, rd_stale, 16'h0100 + 16'(a)); end
    end
    idle(); tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h010F)
      begin errors++; $display("FAIL read_hold got v%b %h exp v0 010f", rd_valid, rd_data); end
  endtask

  task automatic test_premature_swap();
    for (int a = 0; a < 4; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 16'hAAAA; tick();
    end
    idle(); restart = 1; tick(); idle();
    checks++; if (wr_bank !== 1'b0 || swap_err !== 1'b1)
      begin errors++; $display("FAIL premature_swap got bank %b err %b exp 0 1", wr_bank, swap_err); end
    rd_en = 1; rd_addr = 5; tick();
    checks++; if (swap_err !== 1'b0) begin errors++; $display("FAIL swap_err_pulse got %b exp 0", swap_err); end
    checks++; if (rd_data !== 16'h0 || rd_stale !== 1'b1 || rd_valid !== 1'b1)
      begin errors++; $display("FAIL stale_read got %h s%b v%b exp 0000 s1 v1", rd_data, rd_stale, rd_valid); end
    rd_addr = 2; tick(); idle();
    checks++; if (rd_data !== 16'hAAAA || rd_stale !== 1'b0)
      begin errors++; $display("FAIL written_read got %h s%b exp aaaa s0", rd_data, rd_stale); end
  endtask

  task automatic test_same_edge();
    wr_en = 1; wr_addr = 3; wr_data = 16'h5A5A; tick(); idle();
    restart = 1; tick(); idle();
    checks++; if (wr_bank !== 1'b1 || swap_err !== 1'b1)
      begin errors++; $display("FAIL pre_same_edge got bank %b err %b exp 1 1", wr_bank, swap_err); end
    restart = 1; wr_en = 1; wr_addr = 7; wr_data = 16'h1234; rd_en = 1; rd_addr = 3;
    tick(); idle();
    checks++; if (rd_data !== 16'h5A5A || rd_stale !== 1'b0 || wr_bank !== 1'b0)
      begin errors++; $display("FAIL same_edge_read got %h s%b bank %b exp 5a5a s0 0", rd_data, rd_stale, wr_bank); end
    rd_en = 1; rd_addr = 7; tick();
    checks++; if (rd_data !== 16'h1234 || rd_stale !== 1'b0)
      begin errors++; $display("FAIL same_edge_write got %h s%b exp 1234 s0", rd_data, rd_stale); end
    rd_addr = 3; tick(); idle();
    checks++; if (rd_data !== 16'h0 || rd_stale !== 1'b1)
      begin errors++; $display("FAIL cleared_bitmap got %h s%b exp 0000 s1", rd_data, rd_stale); end
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1; rd_addr = 7; tick(); idle();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", rd_valid); end
    rst = 0; tick(); rst = 1;
    checks++; if (rd_valid !== 1'b0 || wr_bank !== 1'b0 || bank_full !== 1'b0)
      begin errors++; $display("FAIL mid_reset got v%b bank %b full %b exp 0 0 0", rd_valid, wr_bank, bank_full); end
    for (int a = 0; a < 16; a += 7) begin
      rd_en = 1; rd_addr = 4'(a); tick();
      checks++; if (rd_stale !== 1'b1 || rd_data !== 16'h0)
        begin errors++; $display("FAIL post_reset_read addr %0d got %h s%b exp 0000 s1", a, rd_data, rd_stale); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_addr = 0; wr_data = 16'h7777; tick(); idle();
    restart = 1; tick();
    checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", wr_bank); end
    tick(); idle();
    checks++; if (wr_bank !== 1'b0 || bank_full !== 1'b0)
      begin errors++; $display("FAIL b2b_second got bank %b full %b exp 0 0", wr_bank, bank_full); end
    restart = 1; tick(); idle();
    rd_en = 1; rd_addr = 0; tick(); idle();
    checks++; if (rd_stale !== 1'b1 || rd_data !== 16'h0)
      begin errors++; $display("FAIL b2b_cleared got %h s%b exp 0000 s1", rd_data, rd_stale); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap_read();
    test_premature_swap();
    test_same_edge();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
